// File: rtl/neo_frame_sequencer.sv
// rtl/neo_frame_sequencer.sv - frame scheduler feeding colour levels and send strobes to a NeoPixel strand controller
module neo_frame_sequencer #(
    parameter int         NUM_PIXELS   = 8,
    parameter int         FRAME_CYCLES = 2500000,
    parameter logic [7:0] LEVEL        = 8'h20
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [1:0] mode,
    input  logic       ready_to_load,
    input  logic       ready_to_send,
    output logic [2:0] pixel_index,
    output logic [1:0] color_index,
    output logic [7:0] color_level,
    output logic       load_color,
    output logic       send_it,
    output logic       frame_done,
    output logic       busy
);

    localparam int              HOLD_W     = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam logic [2:0]      LAST_PIXEL = 3'(NUM_PIXELS - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(FRAME_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_LOAD_GAP,
        S_SEND,
        S_HOLD
    } state_t;

    state_t            state;
    logic [1:0]        mode_q;
    logic [2:0]        head;
    logic [2:0]        pix;
    logic [1:0]        col;
    logic [HOLD_W-1:0] hold_cnt;

    logic [3:0]        rot_sum;
    logic [1:0]        rot_col;
    logic [7:0]        slot_level;

    // Pattern for the slot about to be loaded; mode_q is frozen for the whole frame.
    always_comb begin
        rot_sum    = {1'b0, pix} + {1'b0, head};
        rot_col    = 2'(rot_sum % 4'd3);
        slot_level = 8'h00;
        case (mode_q)
            2'd0: slot_level = LEVEL;
            2'd1: if (pix == head && col == 2'd1) slot_level = LEVEL;
            2'd2: if (col == rot_col) slot_level = LEVEL;
            default: slot_level = 8'h00;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            mode_q      <= 2'd0;
            head        <= 3'd0;
            pix         <= 3'd0;
            col         <= 2'd0;
            hold_cnt    <= '0;
            pixel_index <= 3'd0;
            color_index <= 2'd0;
            color_level <= 8'h00;
            load_color  <= 1'b0;
            send_it     <= 1'b0;
            frame_done  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            load_color <= 1'b0;
            send_it    <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (enable) begin
                        mode_q <= mode;
                        pix    <= 3'd0;
                        col    <= 2'd0;
                        busy   <= 1'b1;
                        state  <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (ready_to_load) begin
                        load_color  <= 1'b1;
                        pixel_index <= pix;
                        color_index <= col;
                        color_level <= slot_level;
                        state       <= S_LOAD_GAP;
                    end
                end
                S_LOAD_GAP: begin
                    if (col == 2'd2) begin
                        col <= 2'd0;
                        pix <= pix + 3'd1;
                        state <= (pix == LAST_PIXEL) ? S_SEND : S_LOAD;
                    end else begin
                        col   <= col + 2'd1;
                        state <= S_LOAD;
                    end
                end
                S_SEND: begin
                    if (ready_to_send) begin
                        send_it  <= 1'b1;
                        hold_cnt <= '0;
                        state    <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        frame_done <= 1'b1;
                        hold_cnt   <= '0;
                        if (mode_q == 2'd1 || mode_q == 2'd2)
                            head <= (head == LAST_PIXEL) ? 3'd0 : head + 3'd1;
                        // Frame boundary: the only point where a new mode is picked up.
                        if (enable) begin
                            mode_q <= mode;
                            pix    <= 3'd0;
                            col    <= 2'd0;
                            state  <= S_LOAD;
                        end else begin
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neo_frame_sequencer.sv
// tb/tb_neo_frame_sequencer.sv - scoreboard bench for neo_frame_sequencer
module tb_neo_frame_sequencer;

    localparam int         NPIX  = 8;
    localparam int         FRAME = 16;
    localparam logic [7:0] LVL   = 8'h20;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic [1:0] mode;
    logic       ready_to_load;
    logic       ready_to_send;
    logic [2:0] pixel_index;
    logic [1:0] color_index;
    logic [7:0] color_level;
    logic       load_color;
    logic       send_it;
    logic       frame_done;
    logic       busy;

    neo_frame_sequencer #(
        .NUM_PIXELS  (NPIX),
        .FRAME_CYCLES(FRAME),
        .LEVEL       (LVL)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .mode         (mode),
        .ready_to_load(ready_to_load),
        .ready_to_send(ready_to_send),
        .pixel_index  (pixel_index),
        .color_index  (color_index),
        .color_level  (color_level),
        .load_color   (load_color),
        .send_it      (send_it),
        .frame_done   (frame_done),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          send_cyc = 0;
    int          loads_total = 0;
    int          loads_in_frame = 0;
    int          sends = 0;
    int          dones = 0;
    int          model_head = 0;
    int          lt;
    int          st;
    logic [13:0] exp_q[$];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        if (obs !== expv) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    function automatic logic [7:0] model_level(input int m, input int p, input int c, input int h);
        case (m)
            0:       return LVL;
            1:       return (p == h && c == 1) ? LVL : 8'h00;
            2:       return (c == (p + h) % 3) ? LVL : 8'h00;
            default: return 8'h00;
        endcase
    endfunction

    task automatic queue_frame(input int m);
        for (int p = 0; p < NPIX; p++)
            for (int c = 0; c < 3; c++)
                exp_q.push_back({1'b0, 3'(p), 2'(c), model_level(m, p, c, model_head)});
        exp_q.push_back({1'b1, 3'(NPIX - 1), 2'd2, model_level(m, NPIX - 1, 2, model_head)});
        if (m == 1 || m == 2) model_head = (model_head == NPIX - 1) ? 0 : model_head + 1;
    endtask

    // sel: 0 loads in current frame, 1 send_it count, 2 frame_done count
    task automatic wait_for(input string tag, input int sel, input int target, input int budget);
        int v;
        v = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            #1;
            v = (sel == 0) ? loads_in_frame : (sel == 1) ? sends : dones;
            if (v >= target) return;
        end
        check_eq({tag, "_timeout"}, 32'(v), 32'(target));
    endtask

    always @(negedge clock) begin
        logic [13:0] e;
        if (reset) begin
            if (load_color && send_it) check_eq("strobe_overlap", 32'd1, 32'd0);
            if (load_color || send_it) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_strobe", {31'd0, send_it}, 32'd2);
                end else begin
                    e = exp_q.pop_front();
                    check_eq(send_it ? "send" : "load",
                             32'({send_it, pixel_index, color_index, color_level}), 32'(e));
                end
            end
            if (load_color) begin
                loads_total++;
                loads_in_frame++;
            end
            if (send_it) begin
                check_eq("loads_per_frame", 32'(loads_in_frame), 32'(3 * NPIX));
                sends++;
                send_cyc = cyc;
                loads_in_frame = 0;
            end
            if (frame_done) begin
                dones++;
                check_eq("hold_len", 32'(cyc - send_cyc), 32'(FRAME));
            end
        end
    end

    initial begin
        reset = 1'b0;
        enable = 1'b0;
        mode = 2'd0;
        ready_to_load = 1'b1;
        ready_to_send = 1'b1;
        repeat (3) @(negedge clock);
        #1;
        check_eq("rst_outputs", 32'({pixel_index, color_index, color_level, load_color, send_it, frame_done, busy}), 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        #1;
        check_eq("idle_busy", 32'(busy), 32'd0);

        // Solid white, send held off after all loads
        mode = 2'd0;
        ready_to_send = 1'b0;
        queue_frame(0);
        enable = 1'b1;
        wait_for("t1_loads", 0, 3 * NPIX, 200);
        repeat (10) @(negedge clock);
        #1;
        check_eq("t1_send_stall", 32'(sends), 32'd0);
        check_eq("t1_busy_stall", 32'(busy), 32'd1);
        ready_to_send = 1'b1;
        wait_for("t1_send", 1, 1, 50);
        mode = 2'd1;
        queue_frame(1);
        wait_for("t1_done", 2, 1, 50);

        // Red chase for nine frames, head wraps on the ninth
        for (int i = 0; i < 9; i++) begin
            wait_for("t2_send", 1, sends + 1, 200);
            if (i == 8) begin
                mode = 2'd2;
                queue_frame(2);
            end else begin
                queue_frame(1);
            end
            wait_for("t2_done", 2, dones + 1, 50);
        end

        // Rotate frame with load stall after the fifth load
        wait_for("t3_load5", 0, 5, 100);
        ready_to_load = 1'b0;
        lt = loads_total;
        repeat (50) @(negedge clock);
        #1;
        check_eq("t3_stall_loads", 32'(loads_total), 32'(lt));
        check_eq("t3_stall_busy", 32'(busy), 32'd1);
        ready_to_load = 1'b1;
        wait_for("t3_send", 1, sends + 1, 200);
        mode = 2'd0;
        queue_frame(0);
        wait_for("t3_done", 2, dones + 1, 50);

        // Enable dropped mid-frame: frame completes, then idle
        wait_for("t4_load10", 0, 10, 100);
        enable = 1'b0;
        wait_for("t4_send", 1, sends + 1, 200);
        wait_for("t4_done", 2, dones + 1, 50);
        repeat (2) @(negedge clock);
        #1;
        lt = loads_total;
        check_eq("t4_idle_busy", 32'(busy), 32'd0);
        check_eq("t4_queue_empty", 32'(exp_q.size()), 32'd0);
        repeat (20) @(negedge clock);
        #1;
        check_eq("t4_idle_loads", 32'(loads_total), 32'(lt));

        // Mode changed 0 -> 3 mid-frame
        mode = 2'd0;
        queue_frame(0);
        enable = 1'b1;
        wait_for("t5_load6", 0, 6, 100);
        mode = 2'd3;
        wait_for("t5_send", 1, sends + 1, 200);
        queue_frame(3);
        wait_for("t5_done", 2, dones + 1, 50);

        // Reset during LOAD of the all-off frame
        wait_for("t6_load4", 0, 4, 100);
        reset = 1'b0;
        #1;
        check_eq("t6_async_outputs", 32'({pixel_index, color_index, color_level, load_color, send_it, frame_done, busy}), 32'd0);
        exp_q.delete();
        loads_in_frame = 0;
        model_head = 0;
        st = sends;
        repeat (5) @(negedge clock);
        #1;
        check_eq("t6_no_send", 32'(sends), 32'(st));
        mode = 2'd1;
        queue_frame(1);
        reset = 1'b1;
        wait_for("t6_send", 1, st + 1, 200);
        enable = 1'b0;
        wait_for("t6_done", 2, dones + 1, 50);
        repeat (2) @(negedge clock);
        #1;
        check_eq("t6_idle_busy", 32'(busy), 32'd0);
        check_eq("t6_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
